msp430_ram_arbiter: RTL and testbench



---
 rtl/msp430_ram_arb_pkg.sv | 22 ++
 rtl/msp430_ram_arb_pick.sv | 25 ++
 rtl/msp430_ram_arbiter.sv | 125 ++++++++++++
 tb/tb_msp430_ram_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/msp430_ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter: master ids, lock-owner
// encoding, the pending-read record and the byte-enable translation.
package msp430_ram_arb_pkg;

  typedef logic master_id_t;

  // Bit 1 set means nobody holds a lock; bit 0 is the owning master otherwise.
  typedef logic [1:0] owner_t;
  localparam owner_t NO_OWNER = 2'b10;

  typedef struct packed {
    logic       valid;
    master_id_t id;
    logic       ok;
  } rd_pend_t;

  // The RAM macro takes low-active byte write enables.
  function automatic logic [1:0] we_to_wen(input logic [1:0] we);
    return ~we;
  endfunction

endpackage

// File: rtl/msp430_ram_arb_pick.sv
// Combinational 2-way picker: an active lock owner is served alone,
// otherwise round-robin against the last granted master.
module msp430_ram_arb_pick
  import msp430_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last,
  input  owner_t     owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (owner != NO_OWNER) begin
      // The other master is refused even while the owner only holds lock.
      if (owner[0]) gnt = {req[1], 1'b0};
      else          gnt = {1'b0, req[0]};
    end else if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/msp430_ram_arbiter.sv
// Shares one single-port msp430_ram between the CPU data port (m0) and a
// DMA/debug port (m1): arbitration, locked sequences, RAM mux, read return.
module msp430_ram_arbiter
  import msp430_ram_arb_pkg::*;
#(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256,
  parameter int LOCK_MAX = 15
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              m0_req,
  input  logic [1:0]        m0_we,
  input  logic [ADDR_MSB:0] m0_addr,
  input  logic [15:0]       m0_din,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic [15:0]       m0_dout,
  output logic              m0_rvalid,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [1:0]        m1_we,
  input  logic [ADDR_MSB:0] m1_addr,
  input  logic [15:0]       m1_din,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic [15:0]       m1_dout,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic              ram_cen,
  output logic [1:0]        ram_wen,
  output logic [ADDR_MSB:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam int WORDS = MEM_SIZE / 2;
  localparam int CW    = $clog2(LOCK_MAX + 1);

  owner_t     owner;
  logic [CW-1:0] lock_cnt;
  master_id_t last;
  rd_pend_t   rd_pend;
  logic [1:0] err_q;

  logic [1:0] req, lock, gnt, gnt_raw;
  logic       any_gnt, forced, owner_act, win_lock, win_ok;
  master_id_t win, pick_last;
  owner_t     pick_owner;
  logic [1:0] win_we;
  logic [ADDR_MSB:0] win_addr;
  logic [CW-1:0] cnt_inc;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};

  // A saturated counter hands the next arbitration to the other master.
  assign forced     = (owner != NO_OWNER) && (lock_cnt == CW'(LOCK_MAX));
  assign owner_act  = (owner != NO_OWNER) && !forced && (req[owner[0]] || lock[owner[0]]);
  assign pick_owner = owner_act ? owner : NO_OWNER;
  assign pick_last  = forced ? owner[0] : last;

  msp430_ram_arb_pick u_pick (
    .req   (req),
    .last  (pick_last),
    .owner (pick_owner),
    .gnt   (gnt_raw)
  );

  assign gnt      = puc_rst ? 2'b00 : gnt_raw;
  assign any_gnt  = |gnt;
  assign win      = gnt[1] | (~gnt[0] & last);
  assign win_we   = win ? m1_we   : m0_we;
  assign win_addr = win ? m1_addr : m0_addr;
  assign win_lock = win ? m1_lock : m0_lock;
  assign win_ok   = 32'(win_addr) < WORDS;
  assign cnt_inc  = (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt : lock_cnt + CW'(1);

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign ram_cen  = ~any_gnt;
  assign ram_wen  = any_gnt ? we_to_wen(win_we) : 2'b11;
  assign ram_addr = win_addr;
  assign ram_din  = win ? m1_din : m0_din;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      owner    <= NO_OWNER;
      lock_cnt <= '0;
      last     <= 1'b1;
      rd_pend  <= '0;
      err_q    <= 2'b00;
    end else begin
      rd_pend.valid <= any_gnt && (win_we == 2'b00);
      rd_pend.id    <= win;
      rd_pend.ok    <= win_ok;
      err_q         <= gnt & {2{~win_ok}};
      if (any_gnt) begin
        last <= win;
        if (!win_lock) begin
          owner    <= NO_OWNER;
          lock_cnt <= '0;
        end else if (owner_act) begin
          lock_cnt <= cnt_inc;
        end else begin
          owner    <= {1'b0, win};
          lock_cnt <= CW'(1);
        end
      end else if (owner_act) begin
        lock_cnt <= cnt_inc;
      end else begin
        owner    <= NO_OWNER;
        lock_cnt <= '0;
      end
    end
  end

  assign m0_rvalid = rd_pend.valid && (rd_pend.id == 1'b0);
  assign m1_rvalid = rd_pend.valid && (rd_pend.id == 1'b1);
  assign m0_dout   = (m0_rvalid && rd_pend.ok) ? ram_dout : 16'h0000;
  assign m1_dout   = (m1_rvalid && rd_pend.ok) ? ram_dout : 16'h0000;
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];

endmodule

// File: tb/tb_msp430_ram_arbiter.sv
// Scoreboard bench for msp430_ram_arbiter with a behavioural msp430_ram
// model; 8-bit word addresses so out-of-range accesses can be exercised.
module tb_msp430_ram_arbiter;
  import msp430_ram_arb_pkg::*;

  localparam int AW       = 8;
  localparam int MEM_SIZE = 256;
  localparam int WORDS    = MEM_SIZE / 2;
  localparam int LOCK_MAX = 15;

  typedef struct packed {
    logic          req;
    logic [1:0]    we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic          lock;
  } mst_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  localparam mst_t IDLE = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req, m0_lock, m0_gnt, m0_rvalid, m0_err;
  logic m1_req, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [1:0] m0_we, m1_we, ram_wen;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [15:0] m0_din, m1_din, m0_dout, m1_dout, ram_din;
  logic [15:0] ram_dout = 16'h0000;
  logic ram_cen;

  logic [15:0] mem    [WORDS];
  logic [15:0] shadow [WORDS];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msp430_ram_arbiter #(.ADDR_MSB(AW-1), .MEM_SIZE(MEM_SIZE), .LOCK_MAX(LOCK_MAX)) dut (
    .mclk(clk), .puc_rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_dout(m0_dout), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_dout(m1_dout), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // RAM macro: ignores out-of-range words and returns a marker there.
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (32'(ram_addr) < WORDS) begin
        if (!ram_wen[0]) mem[ram_addr[AW-2:0]][7:0]  <= ram_din[7:0];
        if (!ram_wen[1]) mem[ram_addr[AW-2:0]][15:8] <= ram_din[15:8];
        ram_dout <= mem[ram_addr[AW-2:0]];
      end else begin
        ram_dout <= 16'hDEAD;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkReturn(input int n, input logic rv, input logic er, input logic [15:0] dd);
    exp_t e;
    if (rv) begin
      if (sb.size() == 0) begin
        checkOutput("rd_spurious", 32'(rv), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rd_master", 32'(n), 32'(e.id));
        checkOutput("rd_data", 32'(dd), 32'(e.data));
        checkOutput("rd_err", 32'(er), 32'(e.err));
      end
    end else if (er) begin
      checkOutput("err_stray", 32'(er), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    checkReturn(0, m0_rvalid, m0_err, m0_dout);
    checkReturn(1, m1_rvalid, m1_err, m1_dout);
  end

  function automatic mst_t rd(input logic [AW-1:0] a, input logic l);
    return '{req: 1'b1, we: 2'b00, addr: a, din: 16'h0000, lock: l};
  endfunction

  function automatic mst_t wr(input logic [AW-1:0] a, input logic [1:0] we,
                              input logic [15:0] d, input logic l);
    return '{req: 1'b1, we: we, addr: a, din: d, lock: l};
  endfunction

  task automatic drive(input mst_t s0, input mst_t s1);
    m0_req = s0.req; m0_we = s0.we; m0_addr = s0.addr; m0_din = s0.din; m0_lock = s0.lock;
    m1_req = s1.req; m1_we = s1.we; m1_addr = s1.addr; m1_din = s1.din; m1_lock = s1.lock;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic applyStimulus(input string tag, input mst_t s0, input mst_t s1, input logic [1:0] exp_gnt);
    mst_t s;
    exp_t e;
    logic [1:0] exp_wen;
    exp_wen = 2'b11;
    drive(s0, s1);
    for (int n = 0; n < 2; n++) begin
      s = (n == 1) ? s1 : s0;
      if (exp_gnt[n]) begin
        exp_wen = ~s.we;
        if (s.we == 2'b00) begin
          e.id   = 1'(n);
          e.err  = 32'(s.addr) >= WORDS;
          e.data = e.err ? 16'h0000 : shadow[s.addr[AW-2:0]];
          sb.push_back(e);
        end else if (32'(s.addr) < WORDS) begin
          if (s.we[0]) shadow[s.addr[AW-2:0]][7:0]  = s.din[7:0];
          if (s.we[1]) shadow[s.addr[AW-2:0]][15:8] = s.din[15:8];
        end
      end
    end
    @(negedge clk);
    checkOutput({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), 32'(exp_gnt));
    checkOutput({tag, "_cen"}, 32'(ram_cen), 32'(exp_gnt == 2'b00));
    checkOutput({tag, "_wen"}, 32'(ram_wen), 32'(exp_wen));
    if (exp_gnt[0]) checkOutput({tag, "_addr"}, 32'(ram_addr), 32'(s0.addr));
    if (exp_gnt[1]) checkOutput({tag, "_addr"}, 32'(ram_addr), 32'(s1.addr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]    = 16'(i * 257) ^ 16'h5A00;
      shadow[i] = 16'(i * 257) ^ 16'h5A00;
    end
    drive(IDLE, IDLE);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    checkOutput("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    checkOutput("rst_err", 32'({m1_err, m0_err}), 32'd0);
    checkOutput("rst_dout", {m1_dout, m0_dout}, 32'd0);
    checkOutput("rst_cen", 32'(ram_cen), 32'd1);
    checkOutput("rst_wen", 32'(ram_wen), 32'd3);
    checkOutput("rst_last", 32'(dut.last), 32'd1);
    checkOutput("rst_owner", 32'(dut.owner), 32'(NO_OWNER));
    checkOutput("rst_cnt", 32'(dut.lock_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] simultaneous reads after reset");
    applyStimulus("rr0", rd(3, 0), rd(5, 0), 2'b01);
    applyStimulus("rr1", IDLE, rd(5, 0), 2'b10);
    applyStimulus("rr2", IDLE, IDLE, 2'b00);

    $display("[TB] full and byte writes");
    applyStimulus("wr_full", IDLE, wr(7, 2'b11, 16'hA55A, 0), 2'b10);
    applyStimulus("wr_lo", wr(7, 2'b01, 16'h1234, 0), IDLE, 2'b01);
    applyStimulus("wr_hi", wr(8, 2'b10, 16'h1234, 0), IDLE, 2'b01);
    applyStimulus("rd7", rd(7, 0), IDLE, 2'b01);
    applyStimulus("rd8", IDLE, rd(8, 0), 2'b10);
    applyStimulus("wr_idle", IDLE, IDLE, 2'b00);

    $display("[TB] locked read-modify-write");
    applyStimulus("rmw_pre", IDLE, rd(9, 0), 2'b10);
    applyStimulus("rmw0", rd(10, 1), rd(5, 0), 2'b01);
    applyStimulus("rmw1", wr(10, 2'b11, 16'hBEEF, 1), rd(5, 0), 2'b01);
    applyStimulus("rmw2", wr(11, 2'b11, 16'h1111, 0), rd(5, 0), 2'b01);
    applyStimulus("rmw3", rd(12, 0), rd(5, 0), 2'b10);
    applyStimulus("rmw4", rd(12, 0), IDLE, 2'b01);
    applyStimulus("rmw5", rd(10, 0), IDLE, 2'b01);

    $display("[TB] lock held to the counter limit");
    for (int k = 1; k <= LOCK_MAX + 1; k++)
      applyStimulus("lockmax", rd(20, 1), (k >= 2) ? rd(21, 0) : IDLE,
                    (k <= LOCK_MAX) ? 2'b01 : 2'b10);
    checkOutput("lockmax_cnt", 32'(dut.lock_cnt), 32'd0);
    checkOutput("lockmax_owner", 32'(dut.owner), 32'(NO_OWNER));
    applyStimulus("lockmax_idle", IDLE, IDLE, 2'b00);

    $display("[TB] out-of-range read");
    applyStimulus("oor", IDLE, rd(200, 0), 2'b10);
    applyStimulus("oor_idle", IDLE, IDLE, 2'b00);
    applyStimulus("oor_after", rd(72, 0), IDLE, 2'b01);

    $display("[TB] reset during lock with read pending");
    drive(IDLE, rd(5, 1));
    @(negedge clk);
    checkOutput("rstlk_gnt", 32'({m1_gnt, m0_gnt}), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstlk_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    checkOutput("rstlk_cen", 32'(ram_cen), 32'd1);
    checkOutput("rstlk_gnt0", 32'({m1_gnt, m0_gnt}), 32'd0);
    checkOutput("rstlk_owner", 32'(dut.owner), 32'(NO_OWNER));
    checkOutput("rstlk_last", 32'(dut.last), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("dual_lock0", rd(30, 1), rd(31, 1), 2'b01);
    applyStimulus("dual_lock1", rd(30, 0), rd(31, 1), 2'b01);
    applyStimulus("dual_lock2", IDLE, rd(31, 0), 2'b10);

    repeat (3) applyStimulus("tail", IDLE, IDLE, 2'b00);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
